// File: rtl/lamp_driver_flash_if.sv
// Lamp driver bus: controller requests in, registered lamp drive and status out.
interface lamp_driver_flash_if #(
    parameter int unsigned N_LAMPS = 7
);
    logic [N_LAMPS-1:0] lights;
    logic [N_LAMPS-1:0] blink_en;
    logic               fault;
    logic               lamp_test;
    logic [N_LAMPS-1:0] lamps;
    logic [1:0]         mode;
    logic               blink_ph;

    modport master (
        output lights, blink_en, fault, lamp_test,
        input  lamps, mode, blink_ph
    );

    modport slave (
        input  lights, blink_en, fault, lamp_test,
        output lamps, mode, blink_ph
    );
endinterface

// File: rtl/lamp_driver_flash.sv
// Registered lamp driver with per-lamp blink, timed lamp test and fault flash.
// Outputs are computed from next-state so lamps and mode always agree in a cycle.
module lamp_driver_flash #(
    parameter int unsigned        N_LAMPS     = 7,
    parameter int unsigned        BLINK_DIV   = 25_000_000,
    parameter int unsigned        TEST_CYCLES = 50_000_000,
    parameter logic [N_LAMPS-1:0] FAULT_MASK  = N_LAMPS'(7'b0100100)
) (
    input  logic                clk,
    input  logic                reset_n,
    lamp_driver_flash_if.slave  bus
);
    localparam int unsigned BW = ($clog2(BLINK_DIV) < 1) ? 1 : $clog2(BLINK_DIV);
    localparam int unsigned TW = ($clog2(TEST_CYCLES) < 1) ? 1 : $clog2(TEST_CYCLES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [TW-1:0] TEST_LOAD  = TW'(TEST_CYCLES - 1);

    typedef enum logic [1:0] {
        S_NORMAL = 2'd0,
        S_FAULT  = 2'd1,
        S_TEST   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BW-1:0]      cnt_q, cnt_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic               ph_q, ph_d;
    logic               lt_q;
    logic [N_LAMPS-1:0] lamps_q, lamps_d;
    logic               lt_rise;

    assign lt_rise = bus.lamp_test & ~lt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_NORMAL;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            ph_q    <= 1'b1;
            lt_q    <= 1'b0;
            lamps_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            ph_q    <= ph_d;
            lt_q    <= bus.lamp_test;
            lamps_q <= lamps_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        lamps_d = '0;

        // Lamp-test edges are only honoured outside TEST, so a test never restarts.
        case (state_q)
            S_NORMAL, S_FAULT: begin
                if (lt_rise) begin
                    state_d = S_TEST;
                    tcnt_d  = TEST_LOAD;
                end else begin
                    state_d = bus.fault ? S_FAULT : S_NORMAL;
                end
            end
            S_TEST: begin
                if (tcnt_q == '0) begin
                    state_d = bus.fault ? S_FAULT : S_NORMAL;
                end else begin
                    tcnt_d = tcnt_q - TW'(1);
                end
            end
            default: state_d = S_NORMAL;
        endcase

        // Every mode change restarts the blink period in its lit half.
        if (state_d != state_q) begin
            cnt_d = '0;
            ph_d  = 1'b1;
        end else if (cnt_q == BLINK_LAST) begin
            cnt_d = '0;
            ph_d  = ~ph_q;
        end else begin
            cnt_d = cnt_q + BW'(1);
        end

        case (state_d)
            S_FAULT: lamps_d = FAULT_MASK & {N_LAMPS{ph_d}};
            S_TEST:  lamps_d = '1;
            default: lamps_d = bus.lights & (~bus.blink_en | {N_LAMPS{ph_d}});
        endcase
    end

    assign bus.lamps    = lamps_q;
    assign bus.mode     = state_q;
    assign bus.blink_ph = ph_q;
endmodule

// File: tb/tb_lamp_driver_flash.sv
// Scoreboard bench for lamp_driver_flash: directed scenarios then random stimulus.
module tb_lamp_driver_flash;
    localparam int          NL = 7;
    localparam int          BD = 4;
    localparam int          TC = 6;
    localparam logic [6:0]  FM = 7'b0100100;

    typedef struct packed {
        logic [6:0] lamps;
        logic [1:0] mode;
        logic       ph;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    lamp_driver_flash_if #(.N_LAMPS(NL)) bus ();

    lamp_driver_flash #(
        .N_LAMPS    (NL),
        .BLINK_DIV  (BD),
        .TEST_CYCLES(TC),
        .FAULT_MASK (FM)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: mode plus cycles spent in it; blink phase derives from that age.
    int   m_mode;
    int   m_age;
    bit   m_lt_prev;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode    = 0;
        m_age     = 0;
        m_lt_prev = 1'b0;
    endtask

    task automatic cycle(input logic [6:0] l, input logic [6:0] b, input logic f, input logic t);
        int   nm;
        bit   ph;
        exp_t e;
        @(negedge clk);
        bus.lights    = l;
        bus.blink_en  = b;
        bus.fault     = f;
        bus.lamp_test = t;
        if (m_mode == 2)
            nm = (m_age >= TC - 1) ? (f ? 1 : 0) : 2;
        else if (t && !m_lt_prev)
            nm = 2;
        else
            nm = f ? 1 : 0;
        m_lt_prev = t;
        m_age     = (nm != m_mode) ? 0 : m_age + 1;
        m_mode    = nm;
        ph        = ((m_age / BD) % 2) == 0;
        e.mode    = 2'(m_mode);
        e.ph      = ph;
        if (m_mode == 1)      e.lamps = ph ? FM : 7'h00;
        else if (m_mode == 2) e.lamps = 7'h7F;
        else                  e.lamps = ph ? l : (l & ~b);
        q.push_back(e);
    endtask

    task automatic repeat_cycle(input int n, input logic [6:0] l, input logic [6:0] b,
                                input logic f, input logic t);
        for (int i = 0; i < n; i++) cycle(l, b, f, t);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_lamps"}, 32'(bus.lamps), 32'h0);
        check({tag, "_mode"},  32'(bus.mode),  32'h0);
        check({tag, "_ph"},    32'(bus.blink_ph), 32'h1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("lamps", 32'(bus.lamps),    32'(e.lamps));
                check("mode",  32'(bus.mode),     32'(e.mode));
                check("ph",    32'(bus.blink_ph), 32'(e.ph));
            end
        end
    end

    initial begin : stim
        logic [6:0] rl, rb;
        logic       rf, rt;

        bus.lights    = 7'b0010001;
        bus.blink_en  = '0;
        bus.fault     = 1'b0;
        bus.lamp_test = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst");
        #1;
        reset_n = 1'b1;

        repeat_cycle(3, 7'b0010001, 7'b0000000, 1'b0, 1'b0);
        repeat_cycle(12, 7'b1001001, 7'b0000001, 1'b0, 1'b0);
        repeat_cycle(12, 7'b1001001, 7'b0000001, 1'b1, 1'b0);
        repeat_cycle(3, 7'b1001001, 7'b0000001, 1'b0, 1'b0);
        repeat_cycle(3, 7'b0110010, 7'b0000000, 1'b0, 1'b1);
        repeat_cycle(1, 7'b0110010, 7'b0000000, 1'b0, 1'b0);
        repeat_cycle(3, 7'b0110010, 7'b0000000, 1'b0, 1'b1);
        repeat_cycle(4, 7'b0110010, 7'b0000000, 1'b0, 1'b0);
        repeat_cycle(12, 7'b0110010, 7'b0010000, 1'b1, 1'b1);
        repeat_cycle(3, 7'b0110010, 7'b0010000, 1'b0, 1'b0);
        repeat_cycle(5, 7'b1000011, 7'b0000011, 1'b0, 1'b0);
        repeat_cycle(3, 7'b1000011, 7'b0000011, 1'b0, 1'b1);

        // Asynchronous reset mid-test and mid-blink, checked before the next edge.
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_state("arst");
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("arst_hold");
        #1;
        model_reset();
        reset_n = 1'b1;

        // lamp_test still high across reset release starts a fresh test.
        repeat_cycle(10, 7'b1000011, 7'b0000011, 1'b0, 1'b1);

        rf = 1'b0;
        rt = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rl = 7'($urandom);
            rb = 7'($urandom);
            if ($urandom_range(15, 0) == 0) rf = ~rf;
            if ($urandom_range(9, 0) == 0)  rt = ~rt;
            cycle(rl, rb, rf, rt);
        end

        repeat (3) @(posedge clk);
        #2;
        check("drain", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
